// File: rtl/nota_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : nota_uart_tx
// Purpose : Sends the ASCII key code of each new note press as an 8N1 UART
//           frame. Define NOTA_UART_RELEASE_EN to also send '.' on release.
// Rev     : 1.0  initial release
// ============================================================================
module nota_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] nota,
  input  logic       contar,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_tx_nxt, w_busy_nxt;

  logic [2:0]       r_nota_q;
  logic             r_contar_q;
  logic             r_pend_valid;
  logic [7:0]       r_pend_byte;

  logic             w_press, w_event, w_consume, w_baud_end;
  logic [7:0]       w_event_byte;

  assign w_press = contar && (nota >= 3'd1) && (nota <= 3'd4) &&
                   (!r_contar_q || (nota != r_nota_q));

`ifdef NOTA_UART_RELEASE_EN
  logic w_release;
  assign w_release    = r_contar_q && !contar;
  assign w_event      = w_press || w_release;
  assign w_event_byte = w_release ? 8'd46 : (8'd96 + {5'd0, nota});
`else
  assign w_event      = w_press;
  assign w_event_byte = 8'd96 + {5'd0, nota};
`endif

  // The FSM drains the buffer only from IDLE; a same-edge refill is not an overrun.
  assign w_consume  = (r_state == S_IDLE) && r_pend_valid;
  assign w_baud_end = (r_baud == C_BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nota_q     <= 3'd0;
      r_contar_q   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_byte  <= 8'd0;
      overrun      <= 1'b0;
    end else begin
      r_nota_q   <= nota;
      r_contar_q <= contar;
      overrun    <= w_event && r_pend_valid && !w_consume;
      if (w_event) begin
        r_pend_valid <= 1'b1;
        r_pend_byte  <= w_event_byte;
      end else if (w_consume) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      tx      <= w_tx_nxt;
      busy    <= w_busy_nxt;
    end
  end

  // tx/busy are computed for the state being entered so they stay registered.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = tx;
    w_busy_nxt  = busy;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (r_pend_valid) begin
          w_shift_nxt = r_pend_byte;
          w_bit_nxt   = 3'd0;
          w_baud_nxt  = '0;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_baud_nxt = r_baud + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nota_uart_tx.sv
`default_nettype none
// Bench for nota_uart_tx: directed scenarios plus random inputs, checked each
// cycle against a timing-level model of events, the one-slot buffer and frames.
module tb_nota_uart_tx;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] nota;
  logic       contar;
  logic       tx, busy, overrun;

  nota_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .nota(nota), .contar(contar),
    .tx(tx), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         cyc = 0;
  logic [2:0] m_nota_q;
  logic       m_contar_q;
  bit         p_valid;
  logic [7:0] p_byte;
  int         free_at;
  bit         f_act;
  int         f_start;
  logic [7:0] f_byte;
  bit         e_ovr;
  int         ovr_seen;
  logic       tx_log[$];
  logic [7:0] dec_b[$];
  int         dec_s[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    bit         ev;
    bit         cons;
    logic [7:0] eb;
    logic       etx, ebusy;
    int         d, idx;
    @(posedge clk);
    cyc++;
    ev = 0;
    eb = 8'd0;
    if (contar && nota >= 3'd1 && nota <= 3'd4 && (!m_contar_q || nota != m_nota_q)) begin
      ev = 1;
      eb = 8'd96 + nota;
    end
`ifdef NOTA_UART_RELEASE_EN
    if (m_contar_q && !contar) begin
      ev = 1;
      eb = 8'd46;
    end
`endif
    cons = p_valid && (cyc >= free_at);
    if (cons) begin
      f_act   = 1;
      f_start = cyc;
      f_byte  = p_byte;
      free_at = cyc + FRAME + 1;
      p_valid = 0;
    end
    e_ovr = ev && p_valid;
    if (ev) begin
      p_valid = 1;
      p_byte  = eb;
    end
    m_nota_q   = nota;
    m_contar_q = contar;
    #1;
    etx   = 1'b1;
    ebusy = 1'b0;
    if (f_act && (cyc - f_start) >= FRAME) f_act = 0;
    if (f_act) begin
      d     = cyc - f_start;
      idx   = d / CPB;
      ebusy = 1'b1;
      if (idx == 0)      etx = 1'b0;
      else if (idx <= 8) etx = f_byte[idx-1];
      else               etx = 1'b1;
    end
    chk("tx", tx, etx);
    chk("busy", busy, ebusy);
    chk("overrun", overrun, e_ovr);
    tx_log.push_back(tx);
    if (overrun === 1'b1) ovr_seen++;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    #1;
    p_valid    = 0;
    f_act      = 0;
    m_nota_q   = 3'd0;
    m_contar_q = 1'b0;
    e_ovr      = 0;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    repeat (n) @(posedge clk);
    cyc += n;
    #2;
    reset   = 1'b0;
    free_at = cyc;
  endtask

  task automatic decode(int a, int b);
    logic [7:0] v;
    dec_b.delete();
    dec_s.delete();
    for (int i = a + 1; i < b && i + FRAME < tx_log.size(); i++) begin
      if (tx_log[i-1] === 1'b1 && tx_log[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) v[k] = tx_log[i + CPB*(k+1) + CPB/2];
        dec_b.push_back(v);
        dec_s.push_back(i);
        i += FRAME - 1;
      end
    end
  endtask

  int pat[10] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 1};
  int base;

  initial begin
    reset  = 1'b1;
    nota   = 3'd0;
    contar = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(2);

    // idle with static inputs
    run(100);

    // press nota=1 and hold
    base   = tx_log.size();
    contar = 1'b1;
    nota   = 3'd1;
    run(200);
    chk("s2_pre_edge", tx_log[base], 1'b1);
    for (int i = 0; i < FRAME; i++) chk("s2_bit", tx_log[base + 1 + i], pat[i / CPB]);
    decode(base, base + 200);
    chk("s2_nframes", dec_b.size(), 1);
    chk("s2_byte", dec_b[0], 8'h61);

    // overwrite of the pending slot while busy
    contar = 1'b0;
    run(60);
    base     = tx_log.size();
    ovr_seen = 0;
    contar   = 1'b1;
    nota     = 3'd2;
    run(10);
    nota = 3'd3;
    run(5);
    nota = 3'd4;
    run(100);
    chk("s3_overruns", ovr_seen, 1);
    decode(base, tx_log.size());
    chk("s3_nframes", dec_b.size(), 2);
    chk("s3_byte0", dec_b[0], 8'h62);
    chk("s3_byte1", dec_b[1], 8'h64);
    chk("s3_gap", dec_s[1] - dec_s[0], FRAME + 1);

    // invalid or absent note codes
    contar = 1'b0;
    run(60);
    base     = tx_log.size();
    ovr_seen = 0;
    contar   = 1'b1;
    nota     = 3'd0;
    run(20);
    nota = 3'd6;
    run(20);
    decode(base, tx_log.size());
    chk("s4_nframes", dec_b.size(), 0);
    chk("s4_overruns", ovr_seen, 0);

    // reset during DATA bit 3
    contar = 1'b0;
    run(60);
    contar = 1'b1;
    nota   = 3'd3;
    run(19);
    chk("s5_busy_mid", busy, 1'b1);
    contar = 1'b0;
    do_reset(2);
    base = tx_log.size();
    run(100);
    decode(base, tx_log.size());
    chk("s5_quiet", dec_b.size(), 0);
    base   = tx_log.size();
    contar = 1'b1;
    nota   = 3'd1;
    run(50);
    decode(base, tx_log.size());
    chk("s5_new_press", dec_b.size(), 1);
    chk("s5_new_byte", dec_b[0], 8'h61);

    // press then release
    contar = 1'b0;
    run(60);
    base   = tx_log.size();
    contar = 1'b1;
    nota   = 3'd4;
    run(10);
    contar = 1'b0;
    run(100);
    decode(base, tx_log.size());
`ifdef NOTA_UART_RELEASE_EN
    chk("s6_nframes", dec_b.size(), 2);
    chk("s6_byte0", dec_b[0], 8'h64);
    chk("s6_byte1", dec_b[1], 8'h2e);
`else
    chk("s6_nframes", dec_b.size(), 1);
    chk("s6_byte0", dec_b[0], 8'h64);
`endif

    // random inputs against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) contar = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) nota = 3'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
